// File: rtl/melody_player.sv
// rtl/melody_player.sv - note-table melody sequencer with built-in PWM tone generator
module melody_player #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned NUM_NOTES   = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic [6:0]        volume,
  output logic              music,
  output logic              busy,
  output logic [ADDR_W-1:0] note_idx,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  localparam logic [31:0]       DIVIDEND = 32'(CLK_FREQ);
  localparam logic [ADDR_W-1:0] MAX_IDX  = ADDR_W'(NUM_NOTES - 1);
  localparam logic [35:0]       BEAT_LEN = 36'(BEAT_CYCLES);
  localparam logic [31:0]       GAP_LAST = 32'(GAP_CYCLES - 1);

  logic [15:0] table_q [NUM_NOTES];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d;
  logic [5:0]        lc_q, lc_d;
  logic [11:0]       freq_q, freq_d;
  logic [3:0]        beats_q, beats_d;
  logic [6:0]        vol_q, vol_d;
  logic [11:0]       rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [31:0]       high_q, high_d;
  logic [35:0]       dur_q, dur_d, dur_cnt_q, dur_cnt_d;
  logic [31:0]       phase_q, phase_d, gap_cnt_q, gap_cnt_d;
  logic              music_q, music_d, busy_q, busy_d, done_q, done_d;

  logic [15:0] entry;
  logic [12:0] rem_shift, div_ext;
  logic [4:0]  beats_ext;
  logic        hold;

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < NUM_NOTES)) table_q[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    lc_d      = lc_q;
    freq_d    = freq_q;
    beats_d   = beats_q;
    vol_d     = vol_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    high_d    = high_q;
    dur_d     = dur_q;
    dur_cnt_d = dur_cnt_q;
    phase_d   = phase_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    entry     = table_q[idx_q];
    rem_shift = {rem_q, quo_q[31]};
    div_ext   = {1'b0, freq_q};
    beats_ext = (beats_q == 4'd0) ? 5'd16 : {1'b0, beats_q};
    hold      = pause && ((state_q == S_PLAY) || (state_q == S_GAP));

    case (state_q)
      S_LOAD: begin
        lc_d = lc_q + 6'd1;
        if (lc_q == 6'd0) begin
          freq_d  = entry[15:4];
          beats_d = entry[3:0];
          vol_d   = volume;
          rem_d   = 12'd0;
          quo_d   = DIVIDEND;
        end else if (lc_q <= 6'd32) begin
          // One restoring-division step per cycle; a rest leaves the divider idle.
          if (freq_q != 12'd0) begin
            if (rem_shift >= div_ext) begin
              rem_d = 12'(rem_shift - div_ext);
              quo_d = {quo_q[30:0], 1'b1};
            end else begin
              rem_d = rem_shift[11:0];
              quo_d = {quo_q[30:0], 1'b0};
            end
          end
        end else begin
          high_d    = 32'((40'(quo_q) * 40'(vol_q)) >> 7);
          dur_d     = 36'(beats_ext) * BEAT_LEN;
          dur_cnt_d = 36'd0;
          phase_d   = 32'd0;
          lc_d      = 6'd0;
          state_d   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (!hold) begin
          if (dur_cnt_q == dur_q - 36'd1) begin
            state_d   = S_GAP;
            phase_d   = 32'd0;
            gap_cnt_d = 32'd0;
          end else begin
            dur_cnt_d = dur_cnt_q + 36'd1;
            phase_d   = (phase_q == quo_q - 32'd1) ? 32'd0 : phase_q + 32'd1;
          end
        end
      end
      S_GAP: begin
        if (!hold) begin
          if (gap_cnt_q == GAP_LAST) begin
            lc_d = 6'd0;
            if (idx_q < last_q) begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = S_LOAD;
            end else if (loop) begin
              idx_d   = '0;
              state_d = S_LOAD;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 32'd1;
          end
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d = S_LOAD;
      idx_d   = '0;
      lc_d    = 6'd0;
      last_d  = (last_idx > MAX_IDX) ? MAX_IDX : last_idx;
      done_d  = 1'b0;
    end
    if (stop) begin
      state_d = S_IDLE;
      lc_d    = 6'd0;
      done_d  = 1'b0;
    end

    busy_d  = (state_d != S_IDLE);
    music_d = (state_d == S_PLAY) && (state_q != S_IDLE) && !(pause && state_q == S_PLAY) &&
              (freq_d != 12'd0) && (phase_d < high_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      lc_q      <= 6'd0;
      freq_q    <= 12'd0;
      beats_q   <= 4'd0;
      vol_q     <= 7'd0;
      rem_q     <= 12'd0;
      quo_q     <= 32'd0;
      high_q    <= 32'd0;
      dur_q     <= 36'd0;
      dur_cnt_q <= 36'd0;
      phase_q   <= 32'd0;
      gap_cnt_q <= 32'd0;
      music_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      lc_q      <= lc_d;
      freq_q    <= freq_d;
      beats_q   <= beats_d;
      vol_q     <= vol_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      high_q    <= high_d;
      dur_q     <= dur_d;
      dur_cnt_q <= dur_cnt_d;
      phase_q   <= phase_d;
      gap_cnt_q <= gap_cnt_d;
      music_q   <= music_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign music    = music_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_melody_player.sv
// tb/tb_melody_player.sv - directed self-checking bench for melody_player
module tb_melody_player;

  localparam int TR = 17000;

  logic       clk = 1'b0;
  logic       rst, wr_en, start, stop, pause, loop, music, busy, done;
  logic [2:0] wr_addr, last_idx, note_idx;
  logic [15:0] wr_data;
  logic [6:0]  volume;

  int vectors = 0;
  int miscompares = 0;

  bit         mus_tr [TR];
  bit         busy_tr[TR];
  bit         done_tr[TR];
  logic [2:0] idx_tr [TR];

  melody_player #(
    .CLK_FREQ(100_000), .NUM_NOTES(8), .ADDR_W(3), .BEAT_CYCLES(1000), .GAP_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_idx(last_idx), .start(start), .stop(stop), .pause(pause), .loop(loop),
    .volume(volume), .music(music), .busy(busy), .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input int freq, input int beats);
    wr_en = 1'b1; wr_addr = a; wr_data = {12'(freq), 4'(beats)};
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic trace(input int n, input int pf, input int pl, input int wk,
                       input logic [2:0] wa, input logic [15:0] wd, input int vk,
                       input logic [6:0] vv);
    for (int k = 0; k < n; k++) begin
      mus_tr[k] = music; busy_tr[k] = busy; done_tr[k] = done; idx_tr[k] = note_idx;
      pause   = (k >= pf) && (k < pf + pl);
      wr_en   = (k == wk);
      wr_addr = wa;
      wr_data = wd;
      if (k == vk) volume = vv;
      tick();
    end
    pause = 1'b0; wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    trace(n, -1, 0, -1, 3'd0, 16'd0, -1, 7'd0);
  endtask

  function automatic int cnt(input int sel, input int a, input int b);
    int c = 0;
    for (int k = a; k < b; k++)
      c += (sel == 0) ? int'(mus_tr[k]) : (sel == 1) ? int'(busy_tr[k]) : int'(done_tr[k]);
    return c;
  endfunction

  function automatic int pat_err(input int a, input int b, input int base, input int per,
                                 input int hi);
    int e = 0;
    for (int k = a; k < b; k++)
      if (mus_tr[k] != (((k - base) % per) < hi)) e++;
    return e;
  endfunction

  initial begin
    wr_en = 0; wr_addr = 0; wr_data = 0; last_idx = 0; start = 0; stop = 0;
    pause = 0; loop = 0; volume = 7'd64;

    // reset with start held high
    rst = 1'b0; start = 1'b1;
    tick(); tick();
    start = 1'b0; rst = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_music", music, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", note_idx, 0);
    tick();
    chk("rst_start_ignored", busy, 0);

    // single one-shot note
    wr(3'd0, 1000, 1);
    last_idx = 3'd0; loop = 1'b0; volume = 7'd64;
    pulse_start();
    run(1050);
    chk("t2_busy_load", busy_tr[0], 1);
    chk("t2_load_silent", cnt(0, 0, 34), 0);
    chk("t2_play_pattern_err", pat_err(34, 1034, 34, 100, 50), 0);
    chk("t2_play_high", cnt(0, 34, 1034), 500);
    chk("t2_gap_silent", cnt(0, 1034, 1044), 0);
    chk("t2_busy_gap_end", busy_tr[1043], 1);
    chk("t2_done", done_tr[1044], 1);
    chk("t2_idle", busy_tr[1044], 0);
    chk("t2_done_once", cnt(2, 0, 1050), 1);

    // looping three-note melody with a rest
    wr(3'd0, 500, 2); wr(3'd1, 0, 1); wr(3'd2, 2000, 1);
    last_idx = 3'd2; loop = 1'b1;
    pulse_start();
    run(4140);
    chk("t3_idx0", idx_tr[2043], 0);
    chk("t3_idx1", idx_tr[2044], 1);
    chk("t3_idx2", idx_tr[3088], 2);
    chk("t3_idx_wrap", idx_tr[4132], 0);
    chk("t3_n0_pattern_err", pat_err(34, 2034, 34, 200, 100), 0);
    chk("t3_rest_silent", cnt(0, 2034, 3122), 0);
    chk("t3_n2_pattern_err", pat_err(3122, 4122, 3122, 50, 25), 0);
    chk("t3_no_done", cnt(2, 0, 4140), 0);
    chk("t3_busy_all", cnt(1, 0, 4140), 4140);
    pulse_stop();

    // zero-beat entry plays 16 beats
    wr(3'd0, 1000, 0);
    last_idx = 3'd0; loop = 1'b0;
    pulse_start();
    run(16050);
    chk("t0b_pattern_err", pat_err(34, 16034, 34, 100, 50), 0);
    chk("t0b_gap_silent", cnt(0, 16034, 16050), 0);
    chk("t0b_busy", busy_tr[16043], 1);
    chk("t0b_done", done_tr[16044], 1);

    // pause for 200 cycles mid-PLAY
    wr(3'd0, 1000, 1);
    pulse_start();
    trace(1250, 154, 200, -1, 3'd0, 16'd0, -1, 7'd0);
    chk("t4_before", mus_tr[154], 1);
    chk("t4_paused_silent", cnt(0, 155, 355), 0);
    chk("t4_resume", mus_tr[355], 1);
    chk("t4_resume_pattern_err", pat_err(355, 1234, 234, 100, 50), 0);
    chk("t4_total_high", cnt(0, 0, 1250), 500);
    chk("t4_busy_gap_end", busy_tr[1243], 1);
    chk("t4_done", done_tr[1244], 1);

    // stop during LOAD and during GAP
    pulse_start();
    run(10);
    pulse_stop();
    chk("t5_stop_load_busy", busy, 0);
    chk("t5_stop_load_music", music, 0);
    run(1200);
    chk("t5_stay_idle", cnt(1, 0, 1200), 0);
    chk("t5_no_done_a", cnt(2, 0, 1200), 0);
    pulse_start();
    run(1037);
    chk("t5_in_gap_busy", busy, 1);
    pulse_stop();
    chk("t5_stop_gap_busy", busy, 0);
    run(30);
    chk("t5_no_done_b", cnt(2, 0, 30), 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t5_start_stop", busy, 0);
    tick();
    chk("t5_start_stop_hold", busy, 0);

    // live table rewrite, full and zero volume
    wr(3'd0, 1000, 1); wr(3'd1, 1000, 1); wr(3'd2, 1000, 1);
    last_idx = 3'd2; loop = 1'b0; volume = 7'd127;
    pulse_start();
    trace(3140, -1, 0, 500, 3'd1, {12'd2000, 4'd1}, 2080, 7'd0);
    chk("t6_vol127_err", pat_err(34, 1034, 34, 100, 99), 0);
    chk("t6_vol127_high", cnt(0, 34, 1034), 990);
    chk("t6_rewrite_err", pat_err(1078, 2078, 1078, 50, 49), 0);
    chk("t6_idx2", idx_tr[2122], 2);
    chk("t6_vol0_silent", cnt(0, 2122, 3122), 0);
    chk("t6_done", done_tr[3132], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
